// File: rtl/mem_bus_arbiter_pkg.sv
// Shared bus encodings and request record for the memory bus arbiter slice.
package mem_bus_arbiter_pkg;

   localparam int XLEN = 32;

   typedef enum logic [1:0] {
      BUS_NONE  = 2'h0,
      BUS_LOAD  = 2'h1,
      BUS_STORE = 2'h2
   } BUS_COMMAND;

   typedef enum logic [1:0] {
      BYTE   = 2'h0,
      HALF   = 2'h1,
      WORD   = 2'h2,
      DOUBLE = 2'h3
   } MEM_SIZE;

   typedef struct packed {
      BUS_COMMAND        command;
      logic [XLEN-1:0]   addr;
      logic [63:0]       data;
      MEM_SIZE           size;
   } MEM_REQ;

   // Requester id width; a single requester still needs one bit.
   function automatic int id_width(input int n);
      return (n > 1) ? $clog2(n) : 1;
   endfunction

endpackage

// File: rtl/mem_bus_arbiter_if.sv
// Requester-side and memory-side signals of the shared memory bus.
// The arbiter attaches through the slave modport; the environment uses master.
interface mem_bus_arbiter_if #(
   parameter int NUM_REQ = 2,
   parameter int TAG_W   = 4
) ();
   import mem_bus_arbiter_pkg::*;

   logic [NUM_REQ-1:0][1:0]       req_command;
   logic [NUM_REQ-1:0][XLEN-1:0]  req_addr;
   logic [NUM_REQ-1:0][63:0]      req_data;
   logic [NUM_REQ-1:0][1:0]       req_size;
   logic [NUM_REQ-1:0][TAG_W-1:0] req_response;
   logic [NUM_REQ-1:0][63:0]      req_rdata;
   logic [NUM_REQ-1:0][TAG_W-1:0] req_tag;

   BUS_COMMAND                    proc2mem_command;
   logic [XLEN-1:0]               proc2mem_addr;
   logic [63:0]                   proc2mem_data;
   MEM_SIZE                       proc2mem_size;
   logic [TAG_W-1:0]              mem2proc_response;
   logic [63:0]                   mem2proc_data;
   logic [TAG_W-1:0]              mem2proc_tag;

   modport slave (
      input  req_command, req_addr, req_data, req_size,
      input  mem2proc_response, mem2proc_data, mem2proc_tag,
      output req_response, req_rdata, req_tag,
      output proc2mem_command, proc2mem_addr, proc2mem_data, proc2mem_size
   );

   modport master (
      output req_command, req_addr, req_data, req_size,
      output mem2proc_response, mem2proc_data, mem2proc_tag,
      input  req_response, req_rdata, req_tag,
      input  proc2mem_command, proc2mem_addr, proc2mem_data, proc2mem_size
   );

endinterface

// File: rtl/mem_tag_owner_table.sv
// Owner table for outstanding load tags: records which requester issued each
// tag, looks up the owner of a returning tag, and flags orphan/collision events.
module mem_tag_owner_table
   import mem_bus_arbiter_pkg::*;
#(
   parameter int TAG_W = 4,
   parameter int ID_W  = 1
) (
   input  logic             clock,
   input  logic             reset,
   input  logic             set_en,
   input  logic [TAG_W-1:0] set_tag,
   input  logic [ID_W-1:0]  set_id,
   input  logic [TAG_W-1:0] ret_tag,
   output logic             hit,
   output logic [ID_W-1:0]  hit_id,
   output logic             orphan_err
);

   localparam int DEPTH = 1 << TAG_W;

   logic [DEPTH-1:0] own_valid;
   logic [ID_W-1:0]  own_id [DEPTH];
   logic             ret_valid;
   logic             collide;

   // Lookup of the returning tag; a same-cycle return frees the entry before reuse.
   always_comb begin
      ret_valid = (ret_tag != '0);
      hit       = ret_valid && own_valid[ret_tag];
      hit_id    = own_id[ret_tag];
      collide   = set_en && own_valid[set_tag] && !(hit && (ret_tag == set_tag));
   end

   // Valid bits: clear on return, then set on accept so a reused tag stays owned.
   always_ff @(posedge clock) begin
      if (reset) begin
         own_valid <= '0;
      end else begin
         if (hit)
            own_valid[ret_tag] <= 1'b0;
         if (set_en)
            own_valid[set_tag] <= 1'b1;
      end
   end

   // Owner ids are only meaningful under a valid bit, so they carry no reset.
   always_ff @(posedge clock) begin
      if (set_en)
         own_id[set_tag] <= set_id;
   end

   // Sticky error: unowned return or accept onto a still-outstanding tag.
   always_ff @(posedge clock) begin
      if (reset)
         orphan_err <= 1'b0;
      else if ((ret_valid && !hit) || collide)
         orphan_err <= 1'b1;
   end

endmodule

// File: rtl/mem_bus_arbiter.sv
// Shares the tagged memory bus between NUM_REQ requesters (0 = fetch,
// 1 = load/store). Round-robin grant, grant held across memory rejects,
// returning load data routed back to the requester that owns the tag.
module mem_bus_arbiter
   import mem_bus_arbiter_pkg::*;
#(
   parameter int NUM_REQ = 2,
   parameter int TAG_W   = 4
) (
   input  logic                clock,
   input  logic                reset,
   mem_bus_arbiter_if.slave    bus,
   output logic                orphan_err
);

   localparam int ID_W = id_width(NUM_REQ);

   MEM_REQ            req [NUM_REQ];
   logic              lock;
   logic [ID_W-1:0]   lock_id;
   logic [ID_W-1:0]   rr_ptr;
   logic [ID_W-1:0]   grant;
   logic [ID_W-1:0]   idx;
   logic              active;
   logic              accept;
   logic              load_set;
   logic              ret_hit;
   logic [ID_W-1:0]   ret_id;

   // Gather each requester's port signals into one request record.
   always_comb begin
      for (int i = 0; i < NUM_REQ; i++) begin
         req[i].command = BUS_COMMAND'(bus.req_command[i]);
         req[i].addr    = bus.req_addr[i];
         req[i].data    = bus.req_data[i];
         req[i].size    = MEM_SIZE'(bus.req_size[i]);
      end
   end

   // Grant: a held lock wins while its requester still asks; else round-robin from rr_ptr.
   always_comb begin
      grant  = rr_ptr;
      active = 1'b0;
      idx    = '0;
      if (lock && (req[lock_id].command != BUS_NONE)) begin
         grant  = lock_id;
         active = 1'b1;
      end else begin
         for (int k = 0; k < NUM_REQ; k++) begin
            idx = ID_W'((int'(rr_ptr) + k) % NUM_REQ);
            if (!active && (req[idx].command != BUS_NONE)) begin
               grant  = idx;
               active = 1'b1;
            end
         end
      end
      accept   = active && (bus.mem2proc_response != '0);
      load_set = accept && (req[grant].command == BUS_LOAD);
   end

   // Bus drive and same-cycle acceptance / return routing back to requesters.
   always_comb begin
      bus.proc2mem_command = active ? req[grant].command : BUS_NONE;
      bus.proc2mem_addr    = req[grant].addr;
      bus.proc2mem_data    = req[grant].data;
      bus.proc2mem_size    = req[grant].size;
      for (int i = 0; i < NUM_REQ; i++) begin
         bus.req_response[i] = (active && (grant == ID_W'(i))) ? bus.mem2proc_response : '0;
         bus.req_tag[i]      = (ret_hit && (ret_id == ID_W'(i))) ? bus.mem2proc_tag : '0;
         bus.req_rdata[i]    = (ret_hit && (ret_id == ID_W'(i))) ? bus.mem2proc_data : '0;
      end
   end

   // Lock and round-robin pointer: accept releases and advances, reject locks, idle releases.
   always_ff @(posedge clock) begin
      if (reset) begin
         lock    <= 1'b0;
         lock_id <= '0;
         rr_ptr  <= '0;
      end else if (accept) begin
         lock   <= 1'b0;
         rr_ptr <= (int'(grant) == NUM_REQ - 1) ? '0 : grant + ID_W'(1);
      end else if (active) begin
         lock    <= 1'b1;
         lock_id <= grant;
      end else begin
         lock <= 1'b0;
      end
   end

   mem_tag_owner_table #(
      .TAG_W (TAG_W),
      .ID_W  (ID_W)
   ) u_owner (
      .clock      (clock),
      .reset      (reset),
      .set_en     (load_set),
      .set_tag    (bus.mem2proc_response),
      .set_id     (grant),
      .ret_tag    (bus.mem2proc_tag),
      .hit        (ret_hit),
      .hit_id     (ret_id),
      .orphan_err (orphan_err)
   );

endmodule

// File: tb/tb_mem_bus_arbiter.sv
// Bench for mem_bus_arbiter: directed vector table, reset-mid-flight sequence,
// and randomized traffic against a tag-ownership reference model.
module tb_mem_bus_arbiter;
   import mem_bus_arbiter_pkg::*;

   localparam int NUM_REQ = 2;
   localparam int TAG_W   = 4;

   localparam logic [31:0] A0 = 32'h0000_0200;
   localparam logic [31:0] A1 = 32'h0000_0100;
   localparam logic [63:0] D0 = 64'h0000_0000_0000_A0A0;
   localparam logic [63:0] D1 = 64'h0000_0000_0000_B1B1;
   localparam logic [1:0]  S0 = 2'd2;
   localparam logic [1:0]  S1 = 2'd3;

   logic clock = 1'b0;
   logic reset = 1'b1;
   logic orphan_err;

   mem_bus_arbiter_if #(.NUM_REQ(NUM_REQ), .TAG_W(TAG_W)) bus ();

   mem_bus_arbiter #(.NUM_REQ(NUM_REQ), .TAG_W(TAG_W)) dut (
      .clock      (clock),
      .reset      (reset),
      .bus        (bus),
      .orphan_err (orphan_err)
   );

   always #5 clock = ~clock;

   int checks   = 0;
   int failures = 0;

   typedef struct {
      logic [1:0]  c0, c1;
      logic [3:0]  resp, rtag;
      logic [63:0] rdata;
      int          eg;
      logic [3:0]  er0, er1, et0, et1;
      logic        eorph;
   } vec_t;

   vec_t vt[$];

   // reference model state
   int m_own[16];
   int m_rr;
   int m_lock;
   bit m_orph;

   function automatic vec_t v(input int c0, input int c1, input int resp, input int rtag,
                              input longint rdata, input int eg, input int er0, input int er1,
                              input int et0, input int et1, input int eorph);
      vec_t x;
      x.c0 = 2'(c0);   x.c1 = 2'(c1);
      x.resp = 4'(resp); x.rtag = 4'(rtag);
      x.rdata = 64'(rdata);
      x.eg = eg;
      x.er0 = 4'(er0); x.er1 = 4'(er1);
      x.et0 = 4'(et0); x.et1 = 4'(et1);
      x.eorph = 1'(eorph);
      return x;
   endfunction

   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s: got %0h expected %0h", name, act, exp);
      end
   endtask

   task automatic drive(input logic [1:0] c0, input logic [1:0] c1,
                        input logic [31:0] a0, input logic [31:0] a1,
                        input logic [63:0] d0, input logic [63:0] d1,
                        input logic [1:0] s0, input logic [1:0] s1,
                        input logic [3:0] resp, input logic [3:0] rtag, input logic [63:0] rdata);
      bus.req_command[0] = c0;  bus.req_command[1] = c1;
      bus.req_addr[0]    = a0;  bus.req_addr[1]    = a1;
      bus.req_data[0]    = d0;  bus.req_data[1]    = d1;
      bus.req_size[0]    = s0;  bus.req_size[1]    = s1;
      bus.mem2proc_response = resp;
      bus.mem2proc_tag      = rtag;
      bus.mem2proc_data     = rdata;
   endtask

   task automatic compare(input string nm, input int eg, input logic [1:0] ecmd,
                          input logic [31:0] eaddr, input logic [63:0] edata, input logic [1:0] esize,
                          input logic [3:0] er0, input logic [3:0] er1,
                          input logic [3:0] et0, input logic [3:0] et1,
                          input logic [63:0] ed0, input logic [63:0] ed1, input logic eorph);
      chk({nm, " p2m_cmd"}, 64'(bus.proc2mem_command), 64'(ecmd));
      if (eg >= 0) begin
         chk({nm, " p2m_addr"}, 64'(bus.proc2mem_addr), 64'(eaddr));
         chk({nm, " p2m_data"}, bus.proc2mem_data, edata);
         chk({nm, " p2m_size"}, 64'(bus.proc2mem_size), 64'(esize));
      end
      chk({nm, " resp0"},  64'(bus.req_response[0]), 64'(er0));
      chk({nm, " resp1"},  64'(bus.req_response[1]), 64'(er1));
      chk({nm, " tag0"},   64'(bus.req_tag[0]), 64'(et0));
      chk({nm, " tag1"},   64'(bus.req_tag[1]), 64'(et1));
      chk({nm, " rdata0"}, bus.req_rdata[0], ed0);
      chk({nm, " rdata1"}, bus.req_rdata[1], ed1);
      chk({nm, " orphan"}, 64'(orphan_err), 64'(eorph));
   endtask

   task automatic apply_row(input string nm, input vec_t r);
      logic [1:0]  ecmd;
      logic [31:0] eaddr;
      logic [63:0] edata;
      logic [1:0]  esize;
      drive(r.c0, r.c1, A0, A1, D0, D1, S0, S1, r.resp, r.rtag, r.rdata);
      #4;
      ecmd  = (r.eg < 0) ? 2'd0 : ((r.eg == 0) ? r.c0 : r.c1);
      eaddr = (r.eg == 1) ? A1 : A0;
      edata = (r.eg == 1) ? D1 : D0;
      esize = (r.eg == 1) ? S1 : S0;
      compare(nm, r.eg, ecmd, eaddr, edata, esize, r.er0, r.er1, r.et0, r.et1,
              (r.et0 != 0) ? r.rdata : 64'd0, (r.et1 != 0) ? r.rdata : 64'd0, r.eorph);
      @(posedge clock);
      #1;
   endtask

   task automatic model_reset();
      for (int t = 0; t < 16; t++) m_own[t] = -1;
      m_rr   = 0;
      m_lock = -1;
      m_orph = 1'b0;
   endtask

   task automatic rand_phase(input int ncyc);
      bit          pend[2];
      logic [1:0]  pc[2], ps[2], cmd[2];
      logic [31:0] pa[2];
      logic [63:0] pd[2];
      logic [3:0]  resp, rtag;
      logic [63:0] rdata;
      logic [3:0]  er[2], et[2];
      logic [63:0] ed[2];
      int          g, owner;
      int          owned[$];
      for (int r = 0; r < 2; r++) begin
         pend[r] = 1'b0; pc[r] = 2'd0; ps[r] = 2'd0; pa[r] = '0; pd[r] = '0;
      end
      for (int n = 0; n < ncyc; n++) begin
         for (int r = 0; r < 2; r++) begin
            if (pend[r]) begin
               if ($urandom_range(7) == 0) pend[r] = 1'b0;
            end else if ($urandom_range(1) == 1) begin
               pend[r] = 1'b1;
               pc[r]   = 2'($urandom_range(2, 1));
               pa[r]   = $urandom;
               pd[r]   = {$urandom, $urandom};
               ps[r]   = 2'($urandom_range(3));
            end
            cmd[r] = pend[r] ? pc[r] : 2'd0;
         end
         resp = ($urandom_range(2) == 0) ? 4'd0 : 4'($urandom_range(15, 1));
         owned.delete();
         for (int t = 1; t < 16; t++) if (m_own[t] >= 0) owned.push_back(t);
         case ($urandom_range(3))
            0:       rtag = 4'($urandom_range(15, 1));
            1:       rtag = (owned.size() > 0) ? 4'(owned[$urandom_range(owned.size() - 1)]) : 4'd0;
            default: rtag = 4'd0;
         endcase
         rdata = {$urandom, $urandom};
         drive(cmd[0], cmd[1], pa[0], pa[1], pd[0], pd[1], ps[0], ps[1], resp, rtag, rdata);

         // expected grant: locked requester if still asking, else first asker from rr
         g = -1;
         if (m_lock >= 0 && cmd[m_lock] != 2'd0) g = m_lock;
         else
            for (int k = 0; k < 2; k++)
               if (g < 0 && cmd[(m_rr + k) % 2] != 2'd0) g = (m_rr + k) % 2;
         owner = (rtag != 0) ? m_own[rtag] : -1;
         for (int r = 0; r < 2; r++) begin
            er[r] = (g == r) ? resp : 4'd0;
            et[r] = (owner == r) ? rtag : 4'd0;
            ed[r] = (owner == r) ? rdata : 64'd0;
         end
         #4;
         compare($sformatf("rnd%0d", n), g, (g >= 0) ? cmd[g] : 2'd0,
                 (g >= 0) ? pa[g] : 32'd0, (g >= 0) ? pd[g] : 64'd0, (g >= 0) ? ps[g] : 2'd0,
                 er[0], er[1], et[0], et[1], ed[0], ed[1], m_orph);

         // state advance at the clock edge
         if (rtag != 0) begin
            if (m_own[rtag] >= 0) m_own[rtag] = -1;
            else m_orph = 1'b1;
         end
         if (g >= 0) begin
            if (resp != 0) begin
               m_lock = -1;
               m_rr   = (g + 1) % 2;
               if (cmd[g] == 2'd1) begin
                  if (m_own[resp] >= 0) m_orph = 1'b1;
                  m_own[resp] = g;
               end
               pend[g] = 1'b0;
            end else begin
               m_lock = g;
            end
         end else begin
            m_lock = -1;
         end
         @(posedge clock);
         #1;
      end
   endtask

   initial begin
      // accept and return
      vt.push_back(v(0,1,3,0,0,             1, 0,3,0,0, 0));
      vt.push_back(v(0,0,0,3,'hDEADBEEF,   -1, 0,0,0,3, 0));
      // round robin 0,1,0,1 then routed returns
      vt.push_back(v(1,1,1,0,0,             0, 1,0,0,0, 0));
      vt.push_back(v(1,1,2,0,0,             1, 0,2,0,0, 0));
      vt.push_back(v(1,1,3,0,0,             0, 3,0,0,0, 0));
      vt.push_back(v(1,1,4,0,0,             1, 0,4,0,0, 0));
      vt.push_back(v(0,0,0,1,'h11,         -1, 0,0,1,0, 0));
      vt.push_back(v(0,0,0,2,'h22,         -1, 0,0,0,2, 0));
      vt.push_back(v(0,0,0,3,'h33,         -1, 0,0,3,0, 0));
      vt.push_back(v(0,0,0,4,'h44,         -1, 0,0,0,4, 0));
      // reject lock: three rejects, accept, then req1
      vt.push_back(v(1,1,0,0,0,             0, 0,0,0,0, 0));
      vt.push_back(v(1,1,0,0,0,             0, 0,0,0,0, 0));
      vt.push_back(v(1,1,0,0,0,             0, 0,0,0,0, 0));
      vt.push_back(v(1,1,5,0,0,             0, 5,0,0,0, 0));
      vt.push_back(v(1,1,6,0,0,             1, 0,6,0,0, 0));
      vt.push_back(v(0,0,0,5,'h55,         -1, 0,0,5,0, 0));
      vt.push_back(v(0,0,0,6,'h66,         -1, 0,0,0,6, 0));
      // tag reuse in the return cycle
      vt.push_back(v(0,1,2,0,0,             1, 0,2,0,0, 0));
      vt.push_back(v(1,0,2,2,'h2222,        0, 2,0,0,2, 0));
      vt.push_back(v(0,0,0,2,'h3333,       -1, 0,0,2,0, 0));
      vt.push_back(v(0,0,0,0,0,            -1, 0,0,0,0, 0));
      // lock overrides rr_ptr=1; store creates no entry; dropped lock releases
      vt.push_back(v(2,0,0,0,0,             0, 0,0,0,0, 0));
      vt.push_back(v(2,1,0,0,0,             0, 0,0,0,0, 0));
      vt.push_back(v(2,1,0,0,0,             0, 0,0,0,0, 0));
      vt.push_back(v(2,1,7,0,0,             0, 7,0,0,0, 0));
      vt.push_back(v(2,1,8,0,0,             1, 0,8,0,0, 0));
      vt.push_back(v(1,0,0,0,0,             0, 0,0,0,0, 0));
      vt.push_back(v(0,1,9,0,0,             1, 0,9,0,0, 0));
      vt.push_back(v(0,0,0,7,'h77,         -1, 0,0,0,0, 0));
      vt.push_back(v(0,0,0,8,'h88,         -1, 0,0,0,8, 1));
      vt.push_back(v(0,0,0,9,'h99,         -1, 0,0,0,9, 1));

      drive(2'd0, 2'd0, A0, A1, D0, D1, S0, S1, 4'd0, 4'd0, 64'd0);
      @(posedge clock);
      #1;
      // outputs while reset is held
      apply_row("rst_state", v(0,0,0,0,0, -1, 0,0,0,0, 0));
      reset = 1'b0;

      for (int i = 0; i < vt.size(); i++)
         apply_row($sformatf("vec%0d", i), vt[i]);

      // reset mid-flight: clean reset, load tag 6, one-cycle reset, tag 6 returns
      reset = 1'b1;
      apply_row("mid_pre", v(0,0,0,0,0, -1, 0,0,0,0, 1));
      reset = 1'b0;
      apply_row("mid_load", v(1,0,6,0,0,  0, 6,0,0,0, 0));
      reset = 1'b1;
      apply_row("mid_rst",  v(0,0,0,0,0, -1, 0,0,0,0, 0));
      reset = 1'b0;
      apply_row("mid_ret",  v(0,0,0,6,'h66, -1, 0,0,0,0, 0));
      apply_row("mid_err",  v(0,0,0,0,0, -1, 0,0,0,0, 1));

      // randomized traffic against the reference model
      reset = 1'b1;
      drive(2'd0, 2'd0, A0, A1, D0, D1, S0, S1, 4'd0, 4'd0, 64'd0);
      @(posedge clock);
      #1;
      reset = 1'b0;
      model_reset();
      rand_phase(2000);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
